// File: rtl/enc_4x2_hs.sv
// rtl/enc_4x2_hs.sv - registered 4-to-2 priority encoder with valid/ready handshake
module enc_4x2_hs #(
    parameter bit PRIORITY_LSB = 1'b0,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       y,
    output logic             multi,
    input  logic             clear_err,
    output logic             err_zero,
    output logic [CNT_W-1:0] count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             accept_nz;
    logic             accept_zero;
    logic             handshake;
    logic [1:0]       win_idx;
    logic             win_multi;
    logic [1:0]       y_q;
    logic             multi_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;

    // The slot can take a new request when empty or when its current result
    // leaves this cycle; reset gates it so nothing is accepted while held.
    assign in_ready    = rst_n & ((state == EMPTY) | out_ready);
    assign accept      = in_valid & in_ready;
    assign accept_nz   = accept & (d != 4'd0);
    assign accept_zero = accept & (d == 4'd0);
    assign handshake   = (state == FULL) & out_ready;

    // Pick the winning bit; clearing the lowest set bit leaves something only for multi-hot d
    always_comb begin
        win_idx = 2'd0;
        if (PRIORITY_LSB) begin
            casez (d)
                4'b???1: win_idx = 2'd0;
                4'b??10: win_idx = 2'd1;
                4'b?100: win_idx = 2'd2;
                4'b1000: win_idx = 2'd3;
                default: win_idx = 2'd0;
            endcase
        end else begin
            casez (d)
                4'b1???: win_idx = 2'd3;
                4'b01??: win_idx = 2'd2;
                4'b001?: win_idx = 2'd1;
                default: win_idx = 2'd0;
            endcase
        end
        win_multi = ((d & (d - 4'd1)) != 4'd0);
    end

    // Next-state: a nonzero accept always fills the slot, a handshake alone empties it
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (accept_nz) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (handshake && !accept_nz) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Result register; a zero accept leaves the previous result untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= 2'd0;
            multi_q <= 1'b0;
        end else if (accept_nz) begin
            y_q     <= win_idx;
            multi_q <= win_multi;
        end
    end

    // Sticky all-zero flag; a simultaneous zero accept beats the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept_zero) begin
            err_q <= 1'b1;
        end else if (clear_err) begin
            err_q <= 1'b0;
        end
    end

    // Saturating count of delivered results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (handshake && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign out_valid = (state == FULL);
    assign y         = y_q;
    assign multi     = multi_q;
    assign err_zero  = err_q;
    assign count     = cnt_q;

endmodule

// File: tb/tb_enc_4x2_hs.sv
// tb/tb_enc_4x2_hs.sv - randomized self-checking bench for enc_4x2_hs
module tb_enc_4x2_hs;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] d;
    logic       out_ready;
    logic       clear_err;

    logic       ir [2];
    logic       ov [2];
    logic [1:0] yy [2];
    logic       ml [2];
    logic       ez [2];
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    logic       m_v     [2];
    logic [1:0] m_y     [2];
    logic       m_multi [2];
    logic       m_err   [2];
    int         m_cnt   [2];
    int         cmax    [2] = '{255, 3};
    bit         lsb_of  [2] = '{1'b0, 1'b1};

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    enc_4x2_hs #(.PRIORITY_LSB(1'b0), .CNT_W(8)) dut_msb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .d(d),
        .out_valid(ov[0]), .out_ready(out_ready), .y(yy[0]), .multi(ml[0]),
        .clear_err(clear_err), .err_zero(ez[0]), .count(cnt_a)
    );

    enc_4x2_hs #(.PRIORITY_LSB(1'b1), .CNT_W(2)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .d(d),
        .out_valid(ov[1]), .out_ready(out_ready), .y(yy[1]), .multi(ml[1]),
        .clear_err(clear_err), .err_zero(ez[1]), .count(cnt_b)
    );

    function automatic int dut_cnt(input int i);
        return (i == 0) ? int'(cnt_a) : int'(cnt_b);
    endfunction

    // Index of the highest (lsb=0) or lowest (lsb=1) set bit
    function automatic logic [1:0] winner(input logic [3:0] v, input bit lsb);
        int r = -1;
        for (int b = 0; b < 4; b++) begin
            if (v[b] && (!lsb || r < 0)) r = b;
        end
        return 2'(r < 0 ? 0 : r);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_v[i] = 1'b0; m_y[i] = 2'd0; m_multi[i] = 1'b0; m_err[i] = 1'b0; m_cnt[i] = 0;
        end
    endtask

    // Advance model by one clock using the inputs currently applied, then step the DUTs
    task automatic tick();
        for (int i = 0; i < 2; i++) begin
            bit rdy, acc, hs;
            rdy = rst_n && (!m_v[i] || out_ready);
            acc = in_valid && rdy;
            hs  = m_v[i] && out_ready;
            if (hs && m_cnt[i] < cmax[i]) m_cnt[i]++;
            if (acc && d != 4'd0) begin
                m_v[i] = 1'b1; m_y[i] = winner(d, lsb_of[i]); m_multi[i] = ($countones(d) > 1);
            end else if (hs) begin
                m_v[i] = 1'b0;
            end
            if (acc && d == 4'd0) m_err[i] = 1'b1;
            else if (clear_err) m_err[i] = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; d = 4'b0100; out_ready = 1'b0; clear_err = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({ir[i], ov[i], yy[i], ml[i], ez[i]} !== 6'd0 || dut_cnt(i) != 0) begin
                n_fail++;
                $display("FAIL reset[%0d]: got rdy=%b v=%b y=%0d m=%b e=%b c=%0d expected all 0",
                         i, ir[i], ov[i], yy[i], ml[i], ez[i], dut_cnt(i));
            end
        end
        rst_n = 1'b1; out_ready = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({ov[i], yy[i], ml[i]} !== {1'b1, 2'd2, 1'b0}) begin
                n_fail++;
                $display("FAIL first_encode[%0d]: got v=%b y=%0d m=%b expected v=1 y=2 m=0", i, ov[i], yy[i], ml[i]);
            end
        end
        in_valid = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (ov[i] !== 1'b0 || dut_cnt(i) != 1) begin
                n_fail++;
                $display("FAIL first_drain[%0d]: got v=%b c=%0d expected v=0 c=1", i, ov[i], dut_cnt(i));
            end
        end
    endtask

    task automatic test_priority();
        in_valid = 1'b1; d = 4'b1010; out_ready = 1'b1;
        tick();
        n_checks++;
        if ({ov[0], yy[0], ml[0]} !== {1'b1, 2'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL priority_msb: got v=%b y=%0d m=%b expected v=1 y=3 m=1", ov[0], yy[0], ml[0]);
        end
        n_checks++;
        if ({ov[1], yy[1], ml[1]} !== {1'b1, 2'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL priority_lsb: got v=%b y=%0d m=%b expected v=1 y=1 m=1", ov[1], yy[1], ml[1]);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        int c0 [2];
        in_valid = 1'b1; d = 4'b0001; out_ready = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) c0[i] = dut_cnt(i);
        d = 4'b1000;
        repeat (4) begin
            #1;
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if ({ir[i], ov[i], yy[i]} !== {1'b0, 1'b1, 2'd0} || dut_cnt(i) != m_cnt[i]) begin
                    n_fail++;
                    $display("FAIL backpressure[%0d]: got rdy=%b v=%b y=%0d c=%0d expected rdy=0 v=1 y=0 c=%0d",
                             i, ir[i], ov[i], yy[i], dut_cnt(i), m_cnt[i]);
                end
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (ir[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_release_ready[%0d]: got %b expected 1", i, ir[i]);
            end
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({ov[i], yy[i]} !== {1'b1, 2'd3} || dut_cnt(i) != c0[i] + 1) begin
                n_fail++;
                $display("FAIL bp_release[%0d]: got v=%b y=%0d c=%0d expected v=1 y=3 c=%0d",
                         i, ov[i], yy[i], dut_cnt(i), c0[i] + 1);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int c0;
        c0 = dut_cnt(0);
        out_ready = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            d = 4'(1 << k);
            tick();
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if ({ov[i], yy[i]} !== {1'b1, 2'(k)}) begin
                    n_fail++;
                    $display("FAIL stream[%0d] step %0d: got v=%b y=%0d expected v=1 y=%0d", i, k, ov[i], yy[i], k);
                end
            end
        end
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (dut_cnt(0) != c0 + 4) begin
            n_fail++;
            $display("FAIL stream_count: got %0d expected %0d", dut_cnt(0), c0 + 4);
        end
    endtask

    task automatic test_zero();
        out_ready = 1'b1; in_valid = 1'b1; d = 4'b0000;
        tick();
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({ov[i], ez[i]} !== 2'b01) begin
                n_fail++;
                $display("FAIL zero_accept[%0d]: got v=%b err=%b expected v=0 err=1", i, ov[i], ez[i]);
            end
        end
        clear_err = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (ez[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL zero_set_wins[%0d]: got err=%b expected 1", i, ez[i]);
            end
        end
        in_valid = 1'b0;
        tick();
        clear_err = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (ez[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL zero_clear[%0d]: got err=%b expected 0", i, ez[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            in_valid  = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 2) != 0);
            d         = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
            clear_err = 1'($urandom_range(0, 9) == 0);
            #1;
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (ir[i] !== (!m_v[i] || out_ready)) begin
                    n_fail++;
                    $display("FAIL rand_ready[%0d] n=%0d: got %b expected %b", i, n, ir[i], !m_v[i] || out_ready);
                end
            end
            tick();
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if ({ov[i], yy[i], ml[i], ez[i]} !== {m_v[i], m_y[i], m_multi[i], m_err[i]} || dut_cnt(i) != m_cnt[i]) begin
                    n_fail++;
                    $display("FAIL rand_out[%0d] n=%0d: got v=%b y=%0d m=%b e=%b c=%0d expected v=%b y=%0d m=%b e=%b c=%0d",
                             i, n, ov[i], yy[i], ml[i], ez[i], dut_cnt(i), m_v[i], m_y[i], m_multi[i], m_err[i], m_cnt[i]);
                end
            end
        end
        in_valid = 1'b0; clear_err = 1'b0;
    endtask

    task automatic test_saturation();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1; out_ready = 1'b1; in_valid = 1'b1; clear_err = 1'b0;
        repeat (5) begin
            d = 4'($urandom_range(1, 15));
            tick();
        end
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (cnt_b !== 2'd3 || cnt_a !== 8'd5) begin
            n_fail++;
            $display("FAIL saturation: got narrow=%0d wide=%0d expected narrow=3 wide=5", cnt_b, cnt_a);
        end
        in_valid = 1'b1; d = 4'b0010; out_ready = 1'b0;
        tick();
        n_checks++;
        if (ov[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_valid: got %b expected 1", ov[0]);
        end
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({ov[i], ir[i]} !== 2'b00 || dut_cnt(i) != 0) begin
                n_fail++;
                $display("FAIL async_reset[%0d]: got v=%b rdy=%b c=%0d expected v=0 rdy=0 c=0", i, ov[i], ir[i], dut_cnt(i));
            end
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_priority();
        test_backpressure();
        test_back_to_back();
        test_zero();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
